// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and an iterative shift-add multiplier.
// Single-cycle ops complete in one clock; MUL retires MUL_BITS multiplier bits per clock.
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1,
    parameter int OPW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   com,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam logic [OPW-1:0] OP_NOP         = OPW'(0);
    localparam logic [OPW-1:0] OP_MOV_REG_REG = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD_REG     = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB_REG     = OPW'(3);
    localparam logic [OPW-1:0] OP_MUL_REG     = OPW'(4);
    localparam logic [OPW-1:0] OP_AND_REG     = OPW'(5);
    localparam logic [OPW-1:0] OP_ORR_REG     = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR_REG     = OPW'(7);

    localparam int ITER = WIDTH / MUL_BITS;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             v;
        logic             err;
    } res_t;

    function automatic res_t alu_op(input logic [OPW-1:0] op,
                                    input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] z);
        res_t       r;
        logic [WIDTH:0] wide;
        r    = '0;
        wide = '0;
        case (op)
            OP_NOP:         r.y = x;
            OP_MOV_REG_REG: r.y = z;
            OP_ADD_REG: begin
                wide = {1'b0, x} + {1'b0, z};
                r.y  = wide[WIDTH-1:0];
                r.c  = wide[WIDTH];
                r.v  = (x[WIDTH-1] == z[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB_REG: begin
                // Extra top bit of the widened difference is the borrow.
                wide = {1'b0, x} - {1'b0, z};
                r.y  = wide[WIDTH-1:0];
                r.c  = wide[WIDTH];
                r.v  = (x[WIDTH-1] != z[WIDTH-1]) && (wide[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND_REG:     r.y = x & z;
            OP_ORR_REG:     r.y = x | z;
            OP_XOR_REG:     r.y = x ^ z;
            default:        r.err = 1'b1;
        endcase
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic                 accept_s;
    logic                 load_s;
    res_t                 ld_s;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign err       = err_q;

    // Partial-product accumulation for one MUL_BITS slice of the multiplier.
    always_comb begin
        acc_step_s = acc_q;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier_q[j]) begin
                acc_step_s = acc_step_s + (mcand_q << j);
            end else begin
                acc_step_s = acc_step_s;
            end
        end
    end

    // Next-state, multiplier datapath and result-load selection.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        ld_s     = '0;
        case (state_q)
            IDLE: begin
                if (accept_s && (com == OP_MUL_REG)) begin
                    state_d  = MUL;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                end else if (accept_s) begin
                    load_s = 1'b1;
                    ld_s   = alu_op(com, a, b);
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                    ld_s.y  = acc_step_s[WIDTH-1:0];
                    ld_s.c  = |acc_step_s[2*WIDTH-1:WIDTH];
                end else begin
                    state_d = MUL;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register: loads a fresh result, otherwise holds until taken.
    always_comb begin
        y_d   = y_q;
        z_d   = z_q;
        n_d   = n_q;
        c_d   = c_q;
        v_d   = v_q;
        err_d = err_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            y_d         = ld_s.y;
            z_d         = (ld_s.y == '0);
            n_d         = ld_s.y[WIDTH-1];
            c_d         = ld_s.c;
            v_d         = ld_s.v;
            err_d       = ld_s.err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
        end
    end

endmodule
